// File: rtl/dmem_preload_pkg.sv
// dmem_preload_pkg: shared state enum and preset image table for dmem_preload.
package dmem_preload_pkg;
  localparam int IMG_COUNT = 5;
  typedef enum logic {LOAD, READY} state_t;
  localparam logic [63:0] IMG_TABLE [IMG_COUNT] = '{
    64'h0000000000000000,
    64'h22A8040322000000,
    64'h0903000000000000,
    64'h411440022006806A,
    64'h0A01000000000000
  };
  // Word 0 sits in the top byte; unknown images and words past 7 read as zero.
  function automatic logic [7:0] img_byte(input logic [2:0] img, input logic [31:0] idx);
    logic [63:0] row;
    row = (img < 3'(IMG_COUNT)) ? IMG_TABLE[img] : '0;
    return (idx < 32'd8) ? row[8*(7-idx[2:0]) +: 8] : 8'h00;
  endfunction
endpackage

// File: rtl/dmem_preload_rom.sv
// dmem_preload_rom: combinational (image, address) -> zero-extended preset word.
module dmem_preload_rom
  import dmem_preload_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic [2:0]        img,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);
  assign word = DATA_W'(img_byte(img, 32'(addr)));
endmodule

// File: rtl/dmem_preload.sv
// dmem_preload: data memory that preloads a preset image after reset or on request.
// Define DMEM_PRELOAD_CHECKSUM_EN to get the image checksum on chk.
module dmem_preload
  import dmem_preload_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        img_sel,
  input  logic              load_req,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        chk
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [2:0] img_q, rom_img;
  logic [DATA_W-1:0] rom_word;
  logic [DATA_W-1:0] mem [DEPTH];
  logic load, last;
  assign load = state == LOAD;
  assign last = cnt == '1;
  assign busy = load;
  // Word 0 is fetched with the live img_sel, the rest with the latched copy.
  assign rom_img = (cnt == '0) ? img_sel : img_q;
  dmem_preload_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rom (
    .img(rom_img),
    .addr(cnt),
    .word(rom_word)
  );
  always_comb begin
    state_nx = state;
    if (load && last) state_nx = READY;
    else if (!load && load_req) state_nx = LOAD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      cnt   <= '0;
      img_q <= '0;
      done  <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      done  <= load && last;
      cnt   <= load ? cnt + 1'b1 : '0;
      rdata <= load ? '0 : mem[raddr];
      if (load && cnt == '0) img_q <= img_sel;
    end
  end
  always_ff @(posedge clk) begin
    if (load) mem[cnt] <= rom_word;
    else if (we) mem[waddr] <= wdata;
  end
`ifdef DMEM_PRELOAD_CHECKSUM_EN
  logic [7:0] acc, acc_nx;
  assign acc_nx = ((cnt == '0) ? 8'h00 : acc) + rom_word[7:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      chk <= '0;
    end else if (load) begin
      acc <= acc_nx;
      if (last) chk <= acc_nx;
    end
  end
`else
  assign chk = '0;
`endif
endmodule

// File: tb/tb_dmem_preload.sv
// tb_dmem_preload: directed plus random stimulus against a behavioural memory model.
module tb_dmem_preload;
  localparam int DEPTH = 8;
`ifdef DMEM_PRELOAD_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] img_sel = 3'd3, waddr = '0, raddr = '0;
  logic load_req = 1'b0, we = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata, chk;
  logic busy, done;
  logic [3:0] raddr16 = '0;
  logic [15:0] rdata16;
  logic busy16, done16;
  logic [7:0] chk16;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  dmem_preload dut (
    .clk(clk), .rst_n(rst_n), .img_sel(img_sel), .load_req(load_req), .we(we),
    .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata), .busy(busy),
    .done(done), .chk(chk)
  );
  dmem_preload #(.DATA_W(16), .DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .img_sel(3'd3), .load_req(1'b0), .we(1'b0),
    .waddr(4'd0), .wdata(16'd0), .raddr(raddr16), .rdata(rdata16), .busy(busy16),
    .done(done16), .chk(chk16)
  );

  logic [7:0] img_tab [5][8] = '{
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h22, 8'hA8, 8'h04, 8'h03, 8'h22, 8'h00, 8'h00, 8'h00},
    '{8'h09, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h41, 8'h14, 8'h40, 8'h02, 8'h20, 8'h06, 8'h80, 8'h6A},
    '{8'h0A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
  };
  function automatic logic [7:0] spec_word(input logic [2:0] img, input int idx);
    return (img < 3'd5 && idx < 8) ? img_tab[img][idx] : 8'h00;
  endfunction

  // Model: words left to load, memory array, expected registered outputs.
  int left, wptr;
  logic [2:0] m_img;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] e_rdata, e_chk, sum;
  logic e_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left = DEPTH; wptr = 0; e_done = 1'b0; e_rdata = '0; e_chk = '0; sum = '0;
    end else if (left > 0) begin
      if (wptr == 0) begin m_img = img_sel; sum = '0; end
      m_mem[wptr] = spec_word(m_img, wptr);
      sum = sum + m_mem[wptr];
      wptr++; left--;
      e_rdata = '0;
      e_done = (left == 0);
      if (left == 0) e_chk = CK_EN ? sum : 8'h00;
    end else begin
      e_done = 1'b0;
      e_rdata = m_mem[raddr];
      if (we) m_mem[waddr] = wdata;
      if (load_req) begin left = DEPTH; wptr = 0; end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    check("busy", 32'(busy), 32'(left > 0));
    check("done", 32'(done), 32'(e_done));
    check("rdata", 32'(rdata), 32'(e_rdata));
    check("chk", 32'(chk), 32'(e_chk));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_load(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin step(); n++; end
  endtask
  task automatic read_all(input logic [2:0] img, input string name);
    for (int a = 0; a < DEPTH; a++) begin
      raddr = 3'(a);
      step();
      check(name, 32'(rdata), 32'(spec_word(img, a)));
    end
  endtask

  initial begin
    int n;
    #12;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_chk", 32'(chk), 32'd0);
    step();
    rst_n = 1'b1;
    wait_load(n);
    check("load3_cycles", 32'(n), 32'd8);
    check("load3_done", 32'(done), 32'd1);
    read_all(3'd3, "img3_word");
    check("img3_lit0", 32'(spec_word(3'd3, 0)), 32'h41);
    // CPU write, then read-during-write returns old data.
    we = 1'b1; waddr = 3'd5; wdata = 8'hFF;
    step();
    we = 1'b0; raddr = 3'd5;
    step();
    check("wr_ff", 32'(rdata), 32'hFF);
    we = 1'b1; wdata = 8'h11;
    step();
    check("rdw_old", 32'(rdata), 32'hFF);
    we = 1'b0;
    step();
    check("rdw_new", 32'(rdata), 32'h11);
    // Reload image 2 while poking writes, reads, img_sel and load_req.
    load_req = 1'b1; img_sel = 3'd2;
    step();
    check("req_busy", 32'(busy), 32'd1);
    load_req = 1'b0;
    step();
    img_sel = 3'd1;
    for (int i = 0; i < 7; i++) begin
      we = 1'($urandom); waddr = 3'($urandom); wdata = 8'($urandom);
      raddr = 3'($urandom); load_req = 1'($urandom);
      step();
      check("load_rdata0", 32'(rdata), 32'd0);
    end
    load_req = 1'b0; we = 1'b0;
    check("load2_done", 32'(done), 32'd1);
    read_all(3'd2, "img2_word");
    check("no_extra_load", 32'(busy), 32'd0);
    // Reset in the middle of an image 4 load, then load image 6.
    load_req = 1'b1; img_sel = 3'd4;
    step();
    load_req = 1'b0;
    repeat (4) step();
    rst_n = 1'b0; img_sel = 3'd6;
    @(negedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;
    wait_load(n);
    check("reload_cycles", 32'(n), 32'd8);
    read_all(3'd6, "img6_word");
    load_req = 1'b1; img_sel = 3'd4;
    step();
    load_req = 1'b0;
    wait_load(n);
    check("img4_chk", 32'(chk), CK_EN ? 32'h0B : 32'h00);
    repeat (400) begin
      img_sel = 3'($urandom); load_req = ($urandom_range(0, 15) == 0);
      we = 1'($urandom); waddr = 3'($urandom); wdata = 8'($urandom); raddr = 3'($urandom);
      step();
    end
    load_req = 1'b0; we = 1'b0;
    wait_load(n);
    check("final_idle", 32'(busy), 32'd0);
    for (int a = 0; a < 16; a++) begin
      raddr16 = 4'(a);
      step();
      check("d16_word", 32'(rdata16), 32'(spec_word(3'd3, a)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
